// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the sequential binary-to-BCD converter.
//   - estado_t: FSM states (IDLE, CONV, FIN)
//   - ANCHO_BIN, NUM_DIG, MAX_VAL, DIG_SAT: default sizing and saturation constants
//   - ANCHO_REG, ANCHO_CNT: derived widths of the shift register and bit counter
package bcd_pkg;

    localparam int          ANCHO_BIN = 14;
    localparam int          NUM_DIG   = 4;
    localparam int          MAX_VAL   = 9999;
    localparam logic [3:0]  DIG_SAT   = 4'd9;

    // Combined {BCD, binary} register and a counter wide enough to hold ANCHO_BIN.
    localparam int          ANCHO_REG = 4 * NUM_DIG + ANCHO_BIN;
    localparam int          ANCHO_CNT = $clog2(ANCHO_BIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } estado_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: request/result bundle between a producer and the converter.
//   valido, dato_bin            : request strobe and binary value (producer -> converter)
//   ocupado, listo              : busy flag and one-cycle result pulse (converter -> producer)
//   desbordamiento              : value exceeded the display range, shown as 9999
//   *_output                    : the four BCD digits, valid while listo is high and held after
//   master modport: producer side; slave modport: converter side.
interface bin_to_bcd_seq_if #(
    parameter int ANCHO_BIN = 14
);
    logic                 valido;
    logic [ANCHO_BIN-1:0] dato_bin;
    logic                 ocupado;
    logic                 listo;
    logic                 desbordamiento;
    logic [3:0]           unidades_output;
    logic [3:0]           decenas_output;
    logic [3:0]           centenas_output;
    logic [3:0]           milesimas_output;

    modport master (
        output valido, dato_bin,
        input  ocupado, listo, desbordamiento,
        input  unidades_output, decenas_output, centenas_output, milesimas_output
    );

    modport slave (
        input  valido, dato_bin,
        output ocupado, listo, desbordamiento,
        output unidades_output, decenas_output, centenas_output, milesimas_output
    );

endinterface

// File: rtl/bcd_ajuste3.sv
// bcd_ajuste3: combinational add-3 correction of one BCD nibble used by double dabble.
//   entrada : current nibble
//   salida  : entrada + 3 when entrada >= 5, otherwise entrada unchanged
module bcd_ajuste3 (
    input  logic [3:0] entrada,
    output logic [3:0] salida
);

    // Adding 3 before the shift makes a nibble >= 5 carry into the next digit after doubling.
    assign salida = (entrada >= 4'd5) ? (entrada + 4'd3) : entrada;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of bin_to_bcd_seq_if (request in, BCD digits / listo / ocupado out)
// A request accepted in IDLE produces listo 15 cycles later for ANCHO_BIN = 14; values above
// MAX_VAL are reported as 9999 with desbordamiento set instead of wrapping into a 5th digit.
module bin_to_bcd_seq #(
    parameter int ANCHO_BIN = bcd_pkg::ANCHO_BIN,
    parameter int NUM_DIG   = bcd_pkg::NUM_DIG,
    parameter int MAX_VAL   = bcd_pkg::MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);
    import bcd_pkg::estado_t;
    import bcd_pkg::IDLE;
    import bcd_pkg::CONV;
    import bcd_pkg::FIN;
    import bcd_pkg::DIG_SAT;

    localparam int ANCHO_REG = 4 * NUM_DIG + ANCHO_BIN;
    localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

    estado_t                estado;
    estado_t                estado_sig;
    logic [ANCHO_REG-1:0]   registro;
    logic [ANCHO_REG-1:0]   registro_ajustado;
    logic [ANCHO_REG-1:0]   registro_desp;
    logic [4*NUM_DIG-1:0]   bcd_ajustado;
    logic [ANCHO_CNT-1:0]   contador;
    logic                   saturado;
    logic                   ultimo_bit;

    logic [3:0]             unidades_q;
    logic [3:0]             decenas_q;
    logic [3:0]             centenas_q;
    logic [3:0]             milesimas_q;
    logic                   desbordamiento_q;

    // One add-3 corrector per BCD nibble of the upper register field.
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_ajuste
        bcd_ajuste3 u_ajuste3 (
            .entrada (registro[ANCHO_BIN + 4*g +: 4]),
            .salida  (bcd_ajustado[4*g +: 4])
        );
    end

    assign registro_ajustado = {bcd_ajustado, registro[ANCHO_BIN-1:0]};
    assign registro_desp     = registro_ajustado << 1;
    assign ultimo_bit        = (contador == ANCHO_CNT'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic: FIN always lasts exactly one cycle, so a request held high
    // through FIN is only taken on the IDLE cycle that follows.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (bus.valido) estado_sig = CONV;
            CONV:    if (ultimo_bit) estado_sig = FIN;
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Datapath. The digit registers are loaded on the edge that enters FIN, straight from
    // the final shifted value, so they are already valid during the listo cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            registro         <= '0;
            contador         <= '0;
            saturado         <= 1'b0;
            unidades_q       <= '0;
            decenas_q        <= '0;
            centenas_q       <= '0;
            milesimas_q      <= '0;
            desbordamiento_q <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (bus.valido) begin
                        registro <= ANCHO_REG'(bus.dato_bin);
                        contador <= ANCHO_CNT'(ANCHO_BIN);
                        saturado <= (int'(bus.dato_bin) > MAX_VAL);
                    end
                end
                CONV: begin
                    registro <= registro_desp;
                    contador <= contador - ANCHO_CNT'(1);
                    if (ultimo_bit) begin
                        desbordamiento_q <= saturado;
                        if (saturado) begin
                            milesimas_q <= DIG_SAT;
                            centenas_q  <= DIG_SAT;
                            decenas_q   <= DIG_SAT;
                            unidades_q  <= DIG_SAT;
                        end else begin
                            milesimas_q <= registro_desp[ANCHO_BIN + 12 +: 4];
                            centenas_q  <= registro_desp[ANCHO_BIN + 8  +: 4];
                            decenas_q   <= registro_desp[ANCHO_BIN + 4  +: 4];
                            unidades_q  <= registro_desp[ANCHO_BIN      +: 4];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ocupado          = (estado != IDLE);
    assign bus.listo            = (estado == FIN);
    assign bus.desbordamiento   = desbordamiento_q;
    assign bus.unidades_output  = unidades_q;
    assign bus.decenas_output   = decenas_q;
    assign bus.centenas_output  = centenas_q;
    assign bus.milesimas_output = milesimas_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq.
// Stimulus pushes the hand-computed digits and the cycle at which listo must appear;
// an independent monitor pops and compares on every listo pulse.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    typedef struct {
        int mil;
        int cen;
        int dec;
        int uni;
        int desb;
        int ciclo;
    } esperado_t;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    int        cyc = 0;
    int        comprobaciones = 0;
    int        errores = 0;
    int        num_listo = 0;
    esperado_t cola[$];
    esperado_t esp;

    bin_to_bcd_seq_if #(.ANCHO_BIN(ANCHO_BIN)) bus ();

    bin_to_bcd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nombre, input int actual, input int requerido);
        comprobaciones++;
        if (actual != requerido) begin
            errores++;
            $display("[TB] FAIL %s: actual=%0d requerido=%0d (t=%0t)", nombre, actual, requerido, $time);
        end
    endtask

    // Monitor: every listo pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.listo) begin
            num_listo++;
            if (cola.size() == 0) begin
                checkOutput("listo_inesperado", 1, 0);
            end else begin
                esp = cola.pop_front();
                checkOutput("ciclo_listo", cyc, esp.ciclo);
                checkOutput("milesimas", int'(bus.milesimas_output), esp.mil);
                checkOutput("centenas", int'(bus.centenas_output), esp.cen);
                checkOutput("decenas", int'(bus.decenas_output), esp.dec);
                checkOutput("unidades", int'(bus.unidades_output), esp.uni);
                checkOutput("desbordamiento", int'(bus.desbordamiento), esp.desb);
                checkOutput("ocupado_en_listo", int'(bus.ocupado), 1);
            end
        end
    end

    // Push an expectation for a request accepted at the next rising edge.
    task automatic pushEsperado(input int mil, cen, dec, uni, desb, input int retraso);
        esperado_t e;
        e.mil = mil; e.cen = cen; e.dec = dec; e.uni = uni; e.desb = desb;
        e.ciclo = cyc + 1 + retraso;
        cola.push_back(e);
    endtask

    // Called just after a falling edge while the DUT is idle; strobes valido for one cycle.
    task automatic applyStimulus(input int valor, input int mil, cen, dec, uni, desb, input bit registrar);
        bus.valido   = 1'b1;
        bus.dato_bin = ANCHO_BIN'(valor);
        if (registrar) pushEsperado(mil, cen, dec, uni, desb, ANCHO_BIN);
        @(negedge clk);
        bus.valido = 1'b0;
    endtask

    // Wait until every expected result has been seen and the DUT is idle again.
    task automatic esperarVacio(input int limite);
        bit ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clk);
            if (cola.size() == 0 && !bus.ocupado) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("espera_fin", int'(ok), 1);
    endtask

    task automatic esperarListo(input int limite);
        bit ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clk);
            if (bus.listo) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("espera_listo", int'(ok), 1);
    endtask

    task automatic checkReposo(input string nombre);
        checkOutput({nombre, "_milesimas"}, int'(bus.milesimas_output), 0);
        checkOutput({nombre, "_centenas"}, int'(bus.centenas_output), 0);
        checkOutput({nombre, "_decenas"}, int'(bus.decenas_output), 0);
        checkOutput({nombre, "_unidades"}, int'(bus.unidades_output), 0);
        checkOutput({nombre, "_desb"}, int'(bus.desbordamiento), 0);
        checkOutput({nombre, "_listo"}, int'(bus.listo), 0);
        checkOutput({nombre, "_ocupado"}, int'(bus.ocupado), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n_ocup;
        int listo_previo;

        bus.valido   = 1'b0;
        bus.dato_bin = '0;

        #1 rst = 1'b1;
        #2 checkReposo("reset");
        #7 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] directed conversions");
        applyStimulus(7609, 7, 6, 0, 9, 0, 1'b1);  esperarVacio(40);
        applyStimulus(3193, 3, 1, 9, 3, 0, 1'b1);  esperarVacio(40);
        applyStimulus(94,   0, 0, 9, 4, 0, 1'b1);  esperarVacio(40);
        applyStimulus(0,    0, 0, 0, 0, 0, 1'b1);  esperarVacio(40);
        applyStimulus(9999, 9, 9, 9, 9, 0, 1'b1);  esperarVacio(40);
        applyStimulus(12000, 9, 9, 9, 9, 1, 1'b1); esperarVacio(40);
        applyStimulus(16383, 9, 9, 9, 9, 1, 1'b1); esperarVacio(40);
        applyStimulus(5,    0, 0, 0, 5, 0, 1'b1);  esperarVacio(40);

        $display("[TB] busy rejection");
        listo_previo = num_listo;
        applyStimulus(1234, 1, 2, 3, 4, 0, 1'b1);
        n_ocup = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.ocupado) n_ocup++;
            else break;
            bus.valido   = (i == 3 || i == 14);
            bus.dato_bin = ANCHO_BIN'(4321);
            @(negedge clk);
        end
        bus.valido = 1'b0;
        checkOutput("ciclos_ocupado", n_ocup, 15);
        checkOutput("listos_rechazo", num_listo - listo_previo, 1);
        checkOutput("cola_rechazo", cola.size(), 0);
        applyStimulus(4321, 4, 3, 2, 1, 0, 1'b1);  esperarVacio(40);

        $display("[TB] reset mid-conversion");
        applyStimulus(5555, 5, 5, 5, 5, 0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1 checkReposo("reset_medio");
        @(negedge clk);
        rst = 1'b0;
        listo_previo = num_listo;
        repeat (20) @(negedge clk);
        checkOutput("listo_abortado", num_listo - listo_previo, 0);
        applyStimulus(42, 0, 0, 4, 2, 0, 1'b1);    esperarVacio(40);

        $display("[TB] back-to-back");
        bus.valido   = 1'b1;
        bus.dato_bin = ANCHO_BIN'(7609);
        pushEsperado(7, 6, 0, 9, 0, ANCHO_BIN);
        pushEsperado(3, 1, 9, 3, 0, ANCHO_BIN + ANCHO_BIN + 2);
        esperarListo(40);
        bus.dato_bin = ANCHO_BIN'(3193);
        esperarListo(40);
        bus.valido = 1'b0;
        esperarVacio(40);

        checkOutput("cola_vacia", cola.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", comprobaciones, errores);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 7-segment decoder stage.
- Accepts a 14-bit binary value with a valid strobe.
- Produces the four BCD digits (unidades, decenas, centenas, milesimas) plus a one-cycle listo pulse that the decoder consumes.

Parameters:
- ANCHO_BIN, 14, width of the binary input (max representable 16383).
- NUM_DIG, 4, number of BCD digits produced (fixed at 4 for this design; kept as a parameter for the shift-register sizing).
- MAX_VAL, 9999, largest value representable on the display; inputs above this saturate.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- valido  input  1  request strobe; sampled only in IDLE.
- dato_bin  input  ANCHO_BIN  binary value to convert; captured on the accepting edge.
- ocupado  output  1  high from the cycle after acceptance until listo has been issued.
- listo  output  1  single-cycle pulse; digit outputs are valid and updated when it is high.
- desbordamiento  output  1  high with listo when the captured value exceeded MAX_VAL; held until the next listo.
- unidades_output  output  4  BCD units digit.
- decenas_output  output  4  BCD tens digit.
- centenas_output  output  4  BCD hundreds digit.
- milesimas_output  output  4  BCD thousands digit.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: all outputs are 0 (digits 0, listo 0, ocupado 0, desbordamiento 0), state IDLE, internal shift register and counter cleared.
- States: IDLE, CONV, FIN.
- IDLE:
  - If valido=1 at a rising edge, capture dato_bin into the binary shift register, clear the BCD field, load bit counter = ANCHO_BIN, and go to CONV.
  - Saturation flag = (dato_bin > MAX_VAL), captured on the same edge.
  - If valido=0, remain in IDLE.
- CONV, once per cycle:
  - Each BCD nibble >= 5 gets +3, computed combinationally.
  - The combined {BCD, bin} register then shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on an edge, the final shift is done and the state moves to FIN.
  - Exactly ANCHO_BIN CONV cycles.
- FIN, one cycle:
  - Register digit outputs from the BCD field, or all 9s if the saturation flag is set.
  - Set desbordamiento = saturation flag and pulse listo=1 for this single cycle.
  - Return to IDLE on the next edge.
- Latency: accepting edge at cycle k → listo high during cycle k+ANCHO_BIN+1 (15 cycles for the default). Throughput is one conversion per ANCHO_BIN+2 cycles.
- ocupado: 1 in CONV and FIN, 0 in IDLE.
- Outputs hold: digit outputs and desbordamiento hold their last value between listo pulses. They never change except in FIN or on reset.
- Simultaneous events:
  - valido high while ocupado=1 is ignored (no queueing, no abort).
  - valido high in the FIN cycle is ignored.
  - It is accepted on the first IDLE cycle after FIN.
- Input stability: dato_bin changes after acceptance do not affect the running conversion.
- Reset mid-conversion: immediate return to IDLE with all reset values. No listo is issued for the aborted request.
- Width rule: internal register is 4*NUM_DIG + ANCHO_BIN = 30 bits. Values 10000–16383 would overflow into a 5th digit and are therefore handled by the saturation path, never by truncation.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum estado_t {IDLE, CONV, FIN};
  - localparams ANCHO_BIN=14, NUM_DIG=4, MAX_VAL=9999, DIG_SAT=4'd9.
- One natural sub-module: bcd_ajuste3. It is a combinational 4-bit correction (in ≥ 5 ? in+3 : in), instantiated NUM_DIG times in a generate loop.

Test Plan:
- Basic conversion: rst high 10 ns then low; valido=1 for one cycle with dato_bin=7609 → listo pulse exactly 15 cycles later. Outputs: milesimas 7, centenas 6, decenas 0, unidades 9, desbordamiento 0.
- Leading zeros and edge values:
  - 3193 → 3,1,9,3.
  - 94 → 0,0,9,4.
  - 0 → 0,0,0,0.
  - 9999 → 9,9,9,9 with desbordamiento 0.
- Saturation: dato_bin=12000 and 16383 → each gives 9,9,9,9 with desbordamiento=1 on listo. A following 5 → 0,0,0,5 with desbordamiento=0.
- Busy rejection: accept 1234, then pulse valido with 4321 at cycles 3 and 14 of the conversion. Required: only one listo with 1,2,3,4; ocupado high 15 cycles; a 4321 request after return to IDLE converts normally.
- Reset mid-operation: accept 5555, assert rst at conversion cycle 7. Required: outputs immediately 0 and listo never pulses; the next request of 42 yields 0,0,4,2 after 15 cycles.
- Back-to-back: valido held high continuously with 7609 then 3193 switched on the listo cycle. Required: listo pulses every 16 cycles with the correct digits each time.
